// File: rtl/rtc_counter.sv
// Real-time seconds counter on the register bus: prescaled tick counting,
// atomic multi-byte snapshot reads, staged preset, alarm/irq and overflow flag.
module rtc_counter #(
  parameter logic [23:0] BASE_ADDR     = 24'h2008,
  parameter int          CNT_BYTES     = 3,
  parameter int          PRESCALE_BITS = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_ce,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        irq
);

  localparam int CW = 8 * CNT_BYTES;

  logic [23:0]              offset;
  logic [CW-1:0]            counter;
  logic [CW-1:0]            cnt_next;
  logic [CW-1:0]            alarm;
  logic [CW-1:0]            preset_val;
  logic [CW-1:0]            cnt_view;
  logic [PRESCALE_BITS-1:0] prescaler;
  logic                     enable;
  logic                     irq_en;
  logic                     alarm_flag;
  logic                     ovf_flag;

  logic ctrl_wr;
  logic clear_stb;
  logic commit;
  logic snap;
  logic tick_inc;
  logic inc;
  logic alarm_set;
  logic ovf_set;

  // Addresses below BASE wrap to huge offsets and decode as unmapped.
  assign offset    = bus_address_in - BASE_ADDR;
  assign ctrl_wr   = bus_write && (offset == 24'd0);
  assign clear_stb = ctrl_wr && bus_data_in[1];
  assign commit    = bus_write && (offset == 24'(CNT_BYTES));
  assign snap      = bus_read && (offset == 24'd1);

  assign cnt_next  = counter + CW'(1);
  assign tick_inc  = enable && tick_ce;
  // Clear and preset commit own the counter on their edge; the tick is dropped.
  assign inc       = tick_inc && (&prescaler) && !clear_stb && !commit;
  assign alarm_set = inc && (cnt_next == alarm);
  assign ovf_set   = inc && (&counter);

  // Staging holds only the lower bytes; the top byte arrives with the commit write.
  generate
    if (CNT_BYTES > 1) begin : g_multi
      logic [CW-9:0] staging;
      logic [CW-9:0] shadow;

      always_ff @(posedge clk) begin
        if (reset) begin
          staging <= '0;
          shadow  <= '0;
        end else begin
          for (int b = 0; b < CNT_BYTES - 1; b++)
            if (bus_write && offset == 24'(b + 1))
              staging[8*b +: 8] <= bus_data_in;
          if (snap)
            shadow <= counter[CW-1:8];
        end
      end

      assign preset_val = {bus_data_in, staging};
      assign cnt_view   = {shadow, counter[7:0]};
    end else begin : g_single
      assign preset_val = bus_data_in;
      assign cnt_view   = counter;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      counter   <= '0;
      prescaler <= '0;
    end else if (clear_stb) begin
      counter   <= '0;
      prescaler <= '0;
    end else if (commit) begin
      counter   <= preset_val;
      prescaler <= '0;
    end else if (tick_inc) begin
      prescaler <= prescaler + PRESCALE_BITS'(1);
      if (&prescaler)
        counter <= cnt_next;
    end
  end

  // Flag sets win over a write-1-clear landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      alarm_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable <= bus_data_in[0];
        irq_en <= bus_data_in[2];
      end
      alarm_flag <= alarm_set || (alarm_flag && !(ctrl_wr && bus_data_in[3]));
      ovf_flag   <= ovf_set   || (ovf_flag   && !(ctrl_wr && bus_data_in[4]));
      irq        <= alarm_flag && irq_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm <= '0;
    end else begin
      for (int b = 0; b < CNT_BYTES; b++)
        if (bus_write && offset == 24'(CNT_BYTES + 1 + b))
          alarm[8*b +: 8] <= bus_data_in;
    end
  end

  always_comb begin
    bus_data_out = 8'h00;
    if (offset == 24'd0)
      bus_data_out = {3'b000, ovf_flag, alarm_flag, irq_en, 1'b0, enable};
    for (int b = 0; b < CNT_BYTES; b++) begin
      if (offset == 24'(b + 1))
        bus_data_out = cnt_view[8*b +: 8];
      if (offset == 24'(CNT_BYTES + 1 + b))
        bus_data_out = alarm[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_rtc_counter.sv
// Directed bench for rtc_counter with PRESCALE_BITS=2, CNT_BYTES=3, BASE 0x2008.
module tb_rtc_counter;
  logic        clk = 1'b0;
  logic        reset;
  logic        tick_ce;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic        irq;

  int nchecks = 0;
  int nerrors = 0;

  rtc_counter #(.BASE_ADDR(24'h2008), .CNT_BYTES(3), .PRESCALE_BITS(2)) dut (
    .clk(clk), .reset(reset), .tick_ce(tick_ce), .bus_write(bus_write),
    .bus_read(bus_read), .bus_address_in(bus_address_in),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [23:0] a, input logic [7:0] d, input logic tk);
    @(negedge clk);
    bus_address_in = a; bus_data_in = d; bus_write = 1'b1; tick_ce = tk;
    @(posedge clk); #1;
    bus_write = 1'b0; tick_ce = 1'b0;
  endtask

  task automatic bus_rd(input logic [23:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_address_in = a; bus_read = 1'b1;
    #1 d = bus_data_out;
    @(posedge clk); #1;
    bus_read = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk); tick_ce = 1'b1;
      @(posedge clk); #1; tick_ce = 1'b0;
    end
  endtask

  task automatic read_count(output logic [23:0] v);
    logic [7:0] b0, b1, b2;
    bus_rd(24'h2009, b0);
    bus_rd(24'h200A, b1);
    bus_rd(24'h200B, b2);
    v = {b2, b1, b0};
  endtask

  task automatic preset(input logic [23:0] v);
    bus_wr(24'h2009, v[7:0], 1'b0);
    bus_wr(24'h200A, v[15:8], 1'b0);
    bus_wr(24'h200B, v[23:16], 1'b0);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic [23:0] v;
    reset = 1'b1; tick_ce = 1'b0; bus_write = 1'b0; bus_read = 1'b0;
    bus_address_in = 24'h0; bus_data_in = 8'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    nchecks++; if (irq !== 1'b0) begin nerrors++; $display("FAIL reset_irq: got %b exp 0", irq); end
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h00) begin nerrors++; $display("FAIL reset_ctrl: got %h exp 00", d); end
    read_count(v);
    nchecks++; if (v !== 24'h0) begin nerrors++; $display("FAIL reset_count: got %h exp 000000", v); end
    bus_rd(24'h200E, d);
    nchecks++; if (d !== 8'h00) begin nerrors++; $display("FAIL reset_alarm2: got %h exp 00", d); end
    bus_rd(24'h2007, d);
    nchecks++; if (d !== 8'h00) begin nerrors++; $display("FAIL unmapped_low: got %h exp 00", d); end
    bus_wr(24'h200C, 8'hAA, 1'b0);
    bus_rd(24'h200F, d);
    nchecks++; if (d !== 8'h00) begin nerrors++; $display("FAIL unmapped_high: got %h exp 00", d); end
    bus_rd(24'h200C, d);
    nchecks++; if (d !== 8'hAA) begin nerrors++; $display("FAIL alarm_rw: got %h exp AA", d); end
    bus_wr(24'h200C, 8'h00, 1'b0);
  endtask

  task automatic test_count;
    logic [7:0] d;
    logic [23:0] v;
    bus_wr(24'h2008, 8'h01, 1'b0);
    ticks(12);
    read_count(v);
    nchecks++; if (v !== 24'h000003) begin nerrors++; $display("FAIL count_12: got %h exp 000003", v); end
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h01) begin nerrors++; $display("FAIL count_ctrl: got %h exp 01", d); end
  endtask

  task automatic test_atomic_read;
    logic [7:0] d;
    logic [23:0] v;
    preset(24'h00FFFF);
    bus_rd(24'h2009, d);
    nchecks++; if (d !== 8'hFF) begin nerrors++; $display("FAIL atomic_b0: got %h exp FF", d); end
    ticks(4);
    bus_rd(24'h200A, d);
    nchecks++; if (d !== 8'hFF) begin nerrors++; $display("FAIL atomic_b1: got %h exp FF", d); end
    bus_rd(24'h200B, d);
    nchecks++; if (d !== 8'h00) begin nerrors++; $display("FAIL atomic_b2: got %h exp 00", d); end
    read_count(v);
    nchecks++; if (v !== 24'h010000) begin nerrors++; $display("FAIL atomic_live: got %h exp 010000", v); end
  endtask

  task automatic test_preset;
    logic [7:0] d;
    logic [23:0] v;
    ticks(2);
    bus_wr(24'h2009, 8'h34, 1'b0);
    bus_wr(24'h200A, 8'h12, 1'b0);
    read_count(v);
    nchecks++; if (v !== 24'h010000) begin nerrors++; $display("FAIL preset_staged: got %h exp 010000", v); end
    bus_wr(24'h200B, 8'h00, 1'b1);
    read_count(v);
    nchecks++; if (v !== 24'h001234) begin nerrors++; $display("FAIL preset_commit: got %h exp 001234", v); end
    ticks(3);
    read_count(v);
    nchecks++; if (v !== 24'h001234) begin nerrors++; $display("FAIL preset_prescale: got %h exp 001234", v); end
    ticks(1);
    read_count(v);
    nchecks++; if (v !== 24'h001235) begin nerrors++; $display("FAIL preset_first_inc: got %h exp 001235", v); end
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h01) begin nerrors++; $display("FAIL preset_ctrl: got %h exp 01", d); end
  endtask

  task automatic test_alarm;
    logic [7:0] d;
    logic [23:0] v;
    bus_wr(24'h2008, 8'h03, 1'b0);
    bus_wr(24'h200C, 8'h05, 1'b0);
    bus_wr(24'h200D, 8'h00, 1'b0);
    bus_wr(24'h200E, 8'h00, 1'b0);
    bus_wr(24'h2008, 8'h05, 1'b0);
    ticks(19);
    nchecks++; if (irq !== 1'b0) begin nerrors++; $display("FAIL alarm_early_irq: got %b exp 0", irq); end
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h05) begin nerrors++; $display("FAIL alarm_early_ctrl: got %h exp 05", d); end
    ticks(1);
    nchecks++; if (irq !== 1'b0) begin nerrors++; $display("FAIL alarm_irq_lag: got %b exp 0", irq); end
    @(posedge clk); #1;
    nchecks++; if (irq !== 1'b1) begin nerrors++; $display("FAIL alarm_irq_high: got %b exp 1", irq); end
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h0D) begin nerrors++; $display("FAIL alarm_flag: got %h exp 0D", d); end
    read_count(v);
    nchecks++; if (v !== 24'h000005) begin nerrors++; $display("FAIL alarm_count: got %h exp 000005", v); end
    bus_wr(24'h2008, 8'h0D, 1'b0);
    nchecks++; if (irq !== 1'b1) begin nerrors++; $display("FAIL alarm_clr_lag: got %b exp 1", irq); end
    @(posedge clk); #1;
    nchecks++; if (irq !== 1'b0) begin nerrors++; $display("FAIL alarm_irq_low: got %b exp 0", irq); end
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h05) begin nerrors++; $display("FAIL alarm_cleared: got %h exp 05", d); end
    preset(24'h000005);
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h05) begin nerrors++; $display("FAIL alarm_no_preset_trig: got %h exp 05", d); end
    nchecks++; if (irq !== 1'b0) begin nerrors++; $display("FAIL alarm_no_preset_irq: got %b exp 0", irq); end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    logic [23:0] v;
    bus_wr(24'h2008, 8'h01, 1'b0);
    preset(24'hFFFFFF);
    ticks(4);
    read_count(v);
    nchecks++; if (v !== 24'h000000) begin nerrors++; $display("FAIL ovf_wrap: got %h exp 000000", v); end
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h11) begin nerrors++; $display("FAIL ovf_flag: got %h exp 11", d); end
    preset(24'hFFFFFF);
    ticks(3);
    bus_wr(24'h2008, 8'h11, 1'b1);
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h11) begin nerrors++; $display("FAIL ovf_set_beats_clr: got %h exp 11", d); end
    read_count(v);
    nchecks++; if (v !== 24'h000000) begin nerrors++; $display("FAIL ovf_wrap2: got %h exp 000000", v); end
    bus_wr(24'h2008, 8'h11, 1'b0);
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h01) begin nerrors++; $display("FAIL ovf_w1c: got %h exp 01", d); end
  endtask

  task automatic test_clear_disable;
    logic [7:0] d;
    logic [23:0] v;
    ticks(6);
    read_count(v);
    nchecks++; if (v !== 24'h000001) begin nerrors++; $display("FAIL clr_midcount: got %h exp 000001", v); end
    bus_wr(24'h2008, 8'h03, 1'b1);
    read_count(v);
    nchecks++; if (v !== 24'h000000) begin nerrors++; $display("FAIL clr_count: got %h exp 000000", v); end
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h01) begin nerrors++; $display("FAIL clr_selfclear: got %h exp 01", d); end
    ticks(3);
    read_count(v);
    nchecks++; if (v !== 24'h000000) begin nerrors++; $display("FAIL clr_prescale: got %h exp 000000", v); end
    ticks(1);
    read_count(v);
    nchecks++; if (v !== 24'h000001) begin nerrors++; $display("FAIL clr_first_inc: got %h exp 000001", v); end
    bus_wr(24'h2008, 8'h03, 1'b0);
    bus_wr(24'h2008, 8'h00, 1'b0);
    ticks(8);
    read_count(v);
    nchecks++; if (v !== 24'h000000) begin nerrors++; $display("FAIL dis_hold: got %h exp 000000", v); end
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h00) begin nerrors++; $display("FAIL dis_ctrl: got %h exp 00", d); end
  endtask

  task automatic test_reset_again;
    logic [7:0] d;
    bus_wr(24'h200C, 8'h5A, 1'b0);
    bus_wr(24'h2008, 8'h05, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    bus_rd(24'h200C, d);
    nchecks++; if (d !== 8'h00) begin nerrors++; $display("FAIL rst2_alarm: got %h exp 00", d); end
    bus_rd(24'h2008, d);
    nchecks++; if (d !== 8'h00) begin nerrors++; $display("FAIL rst2_ctrl: got %h exp 00", d); end
  endtask

  initial begin
    test_reset;
    test_count;
    test_atomic_read;
    test_preset;
    test_alarm;
    test_overflow;
    test_clear_disable;
    test_reset_again;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
